// File: rtl/corr_pkg.sv
// -----------------------------------------------------------------------------
// corr_pkg
// Shared types and constants for the correlator peak-detect channel:
//   CORR_W / CNT_W / EPOCH_W  - correlation, sample-count and epoch widths
//   result_t                  - one closed-window result as held in the FIFO
//   lock_state_e              - lock state machine encoding
//   abs_mag()                 - two's-complement magnitude, exact for -2^63
// -----------------------------------------------------------------------------
package corr_pkg;

  localparam int CORR_W  = 64;
  localparam int CNT_W   = 32;
  localparam int EPOCH_W = 8;

  typedef struct packed {
    logic [CORR_W-1:0]  mag;
    logic [CNT_W-1:0]   cnt;
    logic [EPOCH_W-1:0] epoch;
    logic               above;
  } result_t;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // The magnitude is taken as unsigned, so the most negative input maps to
  // 2^63 without saturating.
  function automatic logic [CORR_W-1:0] abs_mag(input logic [CORR_W-1:0] v);
    return v[CORR_W-1] ? ((~v) + CORR_W'(1)) : v;
  endfunction

endpackage

// File: rtl/corr_result_fifo.sv
// -----------------------------------------------------------------------------
// corr_result_fifo
// First-word-fall-through FIFO of window results.
//   clk, rst     clock, asynchronous active-high reset
//   push         write push_data this cycle
//   push_data    result to store
//   pop          consume head; ignored when empty
//   empty, full  occupancy flags
//   drop         push refused (full and no pop in the same cycle)
//   head         current head entry, all zeros while empty
// -----------------------------------------------------------------------------
module corr_result_fifo
  import corr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  result_t push_data,
  input  logic    pop,
  output logic    empty,
  output logic    full,
  output logic    drop,
  output result_t head
);

  localparam int AW = $clog2(DEPTH);

  result_t         mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            pop_ok;
  logic            push_ok;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (AW+1)'(DEPTH));
    pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok = push && (!full || pop_ok);
    drop    = push && !push_ok;
    wptr_d  = wptr_q + AW'(push_ok);
    rptr_d  = rptr_q + AW'(pop_ok);
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    head    = empty ? '0 : mem_q[rptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, and head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/corr_peak_detect.sv
// -----------------------------------------------------------------------------
// corr_peak_detect
// Tracks the peak correlation magnitude over a programmable window of epochs,
// queues one result per closed window and drives a lock state machine from
// consecutive above-threshold windows.
//   clk, rst        clock, asynchronous active-high reset
//   enable          run; low aborts the open window and idles the tracker
//   corr_valid      one-cycle strobe for a new epoch correlation
//   corr_value      signed correlation sum
//   corr_cnt        sample count at epoch end
//   win_len         epochs per window (0 acts as 1), sampled at window start
//   threshold       unsigned magnitude threshold, compared at window close
//   res_pop         consume FIFO head
//   clear_ovf       clear the sticky overflow flag
//   res_valid       FIFO head valid
//   res_mag/cnt/epoch/above  FIFO head fields
//   fifo_full       FIFO holds FIFO_DEPTH entries
//   overflow        sticky: a window result was dropped
//   lock            channel locked
// Pipeline: strobe registered at E0, window update/close at E1, FIFO write
// at E2 through a write register.
// -----------------------------------------------------------------------------
module corr_peak_detect
  import corr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LOCK_N     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               corr_valid,
  input  logic [CORR_W-1:0]  corr_value,
  input  logic [CNT_W-1:0]   corr_cnt,
  input  logic [EPOCH_W-1:0] win_len,
  input  logic [CORR_W-1:0]  threshold,
  input  logic               res_pop,
  input  logic               clear_ovf,
  output logic               res_valid,
  output logic [CORR_W-1:0]  res_mag,
  output logic [CNT_W-1:0]   res_cnt,
  output logic [EPOCH_W-1:0] res_epoch,
  output logic               res_above,
  output logic               fifo_full,
  output logic               overflow,
  output logic               lock
);

  localparam int RUN_W = $clog2(LOCK_N + 1);

  // Stage 1: registered magnitude
  logic               s1_valid_q, s1_valid_d;
  logic [CORR_W-1:0]  s1_mag_q,   s1_mag_d;
  logic [CNT_W-1:0]   s1_cnt_q,   s1_cnt_d;

  // Stage 2: window tracker
  logic [EPOCH_W-1:0] ep_q,     ep_d;
  logic [EPOCH_W-1:0] wl_q,     wl_d;
  logic [CORR_W-1:0]  peak_q,   peak_d;
  logic [CNT_W-1:0]   pk_cnt_q, pk_cnt_d;
  logic [EPOCH_W-1:0] pk_ep_q,  pk_ep_d;
  logic [EPOCH_W-1:0] wl_eff;
  logic               first;
  logic               close;
  result_t            close_res;

  // Write register in front of the FIFO
  logic               wr_valid_q, wr_valid_d;
  result_t            wr_data_q,  wr_data_d;

  logic               overflow_q, overflow_d;

  // Lock FSM
  lock_state_e        state_q;
  logic [RUN_W-1:0]   run_q;
  logic               lock_q;

  logic               fifo_empty;
  logic               fifo_drop;
  result_t            head;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned and infers a latch.
  always_comb begin
    s1_valid_d = enable && corr_valid;
    s1_mag_d   = s1_mag_q;
    s1_cnt_d   = s1_cnt_q;
    if (enable && corr_valid) begin
      s1_mag_d = abs_mag(corr_value);
      s1_cnt_d = corr_cnt;
    end

    first    = (ep_q == '0);
    wl_eff   = first ? ((win_len == '0) ? EPOCH_W'(1) : win_len) : wl_q;
    ep_d     = ep_q;
    wl_d     = wl_q;
    peak_d   = peak_q;
    pk_cnt_d = pk_cnt_q;
    pk_ep_d  = pk_ep_q;
    close    = 1'b0;

    if (!enable) begin
      ep_d = '0;
    end else if (s1_valid_q) begin
      wl_d = wl_eff;
      // Strict compare: a tie keeps the earlier epoch.
      if (first || (s1_mag_q > peak_q)) begin
        peak_d   = s1_mag_q;
        pk_cnt_d = s1_cnt_q;
        pk_ep_d  = ep_q;
      end
      if (ep_q == (wl_eff - EPOCH_W'(1))) begin
        close = 1'b1;
        ep_d  = '0;
      end else begin
        ep_d = ep_q + EPOCH_W'(1);
      end
    end

    // Threshold applies to the final peak, including the closing epoch.
    close_res = '{mag: peak_d, cnt: pk_cnt_d, epoch: pk_ep_d,
                  above: (peak_d >= threshold)};

    wr_valid_d = close;
    wr_data_d  = close ? close_res : wr_data_q;

    // A drop in the same cycle as clear_ovf leaves the flag set.
    overflow_d = fifo_drop || (overflow_q && !clear_ovf);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mag_q   <= '0;
      s1_cnt_q   <= '0;
      ep_q       <= '0;
      wl_q       <= '0;
      peak_q     <= '0;
      pk_cnt_q   <= '0;
      pk_ep_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mag_q   <= s1_mag_d;
      s1_cnt_q   <= s1_cnt_d;
      ep_q       <= ep_d;
      wl_q       <= wl_d;
      peak_q     <= peak_d;
      pk_cnt_q   <= pk_cnt_d;
      pk_ep_q    <= pk_ep_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Lock FSM, advanced only at window close. It runs from the closing
  // result directly, so a dropped FIFO entry still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
      run_q   <= '0;
      lock_q  <= 1'b0;
    end else if (!enable) begin
      state_q <= SEARCH;
      run_q   <= '0;
      lock_q  <= 1'b0;
    end else if (close) begin
      case (state_q)
        SEARCH: begin
          if (close_res.above) begin
            if (run_q == RUN_W'(LOCK_N - 1)) begin
              state_q <= LOCKED;
              run_q   <= '0;
              lock_q  <= 1'b1;
            end else begin
              run_q <= run_q + RUN_W'(1);
            end
          end else begin
            run_q <= '0;
          end
        end
        LOCKED: begin
          if (!close_res.above) begin
            state_q <= SEARCH;
            run_q   <= '0;
            lock_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= SEARCH;
          run_q   <= '0;
          lock_q  <= 1'b0;
        end
      endcase
    end
  end

  corr_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid_q),
    .push_data (wr_data_q),
    .pop       (res_pop),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .drop      (fifo_drop),
    .head      (head)
  );

  assign res_valid = !fifo_empty;
  assign res_mag   = head.mag;
  assign res_cnt   = head.cnt;
  assign res_epoch = head.epoch;
  assign res_above = head.above;
  assign overflow  = overflow_q;
  assign lock      = lock_q;

endmodule

// File: tb/tb_corr_peak_detect.sv
// -----------------------------------------------------------------------------
// tb_corr_peak_detect
// Directed scenarios followed by randomized traffic. A transaction-level model
// (window sample lists, a result queue, a run counter) predicts every output
// and is compared each cycle on the falling edge; a few literal expectations
// pin the model on hand-worked cases.
// -----------------------------------------------------------------------------
module tb_corr_peak_detect;
  import corr_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int LOCK_N     = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b1;
  logic               corr_valid = 1'b0;
  logic [CORR_W-1:0]  corr_value = '0;
  logic [CNT_W-1:0]   corr_cnt = '0;
  logic [EPOCH_W-1:0] win_len = '0;
  logic [CORR_W-1:0]  threshold = '0;
  logic               res_pop = 1'b0;
  logic               clear_ovf = 1'b0;
  logic               res_valid;
  logic [CORR_W-1:0]  res_mag;
  logic [CNT_W-1:0]   res_cnt;
  logic [EPOCH_W-1:0] res_epoch;
  logic               res_above;
  logic               fifo_full;
  logic               overflow;
  logic               lock;

  int n_checks = 0;
  int n_errors = 0;

  corr_peak_detect #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .LOCK_N    (LOCK_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .corr_valid (corr_valid),
    .corr_value (corr_value),
    .corr_cnt   (corr_cnt),
    .win_len    (win_len),
    .threshold  (threshold),
    .res_pop    (res_pop),
    .clear_ovf  (clear_ovf),
    .res_valid  (res_valid),
    .res_mag    (res_mag),
    .res_cnt    (res_cnt),
    .res_epoch  (res_epoch),
    .res_above  (res_above),
    .fifo_full  (fifo_full),
    .overflow   (overflow),
    .lock       (lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  result_t           mq[$];          // results visible at the FIFO
  logic [CORR_W-1:0] win_mag[$];     // epochs of the open window
  logic [CNT_W-1:0]  win_cnt[$];
  int                m_wl;
  logic              m_pend_v;       // epoch strobed, not yet in window
  logic [CORR_W-1:0] m_pend_mag;
  logic [CNT_W-1:0]  m_pend_cnt;
  logic              m_res_v;        // window closed, not yet in FIFO
  result_t           m_res;
  logic              m_ovf;
  logic              m_lock;
  int                m_run;

  function automatic logic [CORR_W-1:0] magnitude(input logic [CORR_W-1:0] v);
    return v[CORR_W-1] ? (64'd0 - v) : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    win_mag.delete();
    win_cnt.delete();
    m_wl = 1;
    m_pend_v = 1'b0;
    m_pend_mag = '0;
    m_pend_cnt = '0;
    m_res_v = 1'b0;
    m_res = '0;
    m_ovf = 1'b0;
    m_lock = 1'b0;
    m_run = 0;
  endtask

  task automatic model_step();
    bit      pop_ok, drop, new_v;
    result_t new_r;
    int      best;
    pop_ok = res_pop && (mq.size() > 0);
    drop   = m_res_v && (mq.size() == FIFO_DEPTH) && !pop_ok;
    if (pop_ok) void'(mq.pop_front());
    if (m_res_v && !drop) mq.push_back(m_res);
    if (drop) m_ovf = 1'b1;
    else if (clear_ovf) m_ovf = 1'b0;

    new_v = 1'b0;
    new_r = '0;
    if (!enable) begin
      win_mag.delete();
      win_cnt.delete();
      m_run = 0;
      m_lock = 1'b0;
    end else if (m_pend_v) begin
      if (win_mag.size() == 0) m_wl = (win_len == 0) ? 1 : int'(win_len);
      win_mag.push_back(m_pend_mag);
      win_cnt.push_back(m_pend_cnt);
      if (win_mag.size() == m_wl) begin
        best = 0;
        foreach (win_mag[i]) if (win_mag[i] > win_mag[best]) best = i;
        new_r.mag   = win_mag[best];
        new_r.cnt   = win_cnt[best];
        new_r.epoch = 8'(best);
        new_r.above = (win_mag[best] >= threshold);
        new_v = 1'b1;
        if (m_lock) begin
          if (!new_r.above) begin
            m_lock = 1'b0;
            m_run = 0;
          end
        end else if (new_r.above) begin
          m_run++;
          if (m_run >= LOCK_N) begin
            m_lock = 1'b1;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
        win_mag.delete();
        win_cnt.delete();
      end
    end
    m_res_v = new_v;
    m_res   = new_r;

    m_pend_v = enable && corr_valid;
    if (enable && corr_valid) begin
      m_pend_mag = magnitude(corr_value);
      m_pend_cnt = corr_cnt;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Compare process: DUT against model on every falling edge out of reset.
  initial begin
    result_t h;
    forever begin
      @(negedge clk);
      if (!rst) begin
        h = (mq.size() > 0) ? mq[0] : '0;
        check("res_valid", 64'(res_valid), 64'(mq.size() > 0));
        check("res_mag",   64'(res_mag),   64'(h.mag));
        check("res_cnt",   64'(res_cnt),   64'(h.cnt));
        check("res_epoch", 64'(res_epoch), 64'(h.epoch));
        check("res_above", 64'(res_above), 64'(h.above));
        check("fifo_full", 64'(fifo_full), 64'(mq.size() == FIFO_DEPTH));
        check("overflow",  64'(overflow),  64'(m_ovf));
        check("lock",      64'(lock),      64'(m_lock));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (each starts and ends just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [63:0] v, input logic [31:0] c);
    corr_valid = 1'b1;
    corr_value = v;
    corr_cnt   = c;
    @(negedge clk);
    corr_valid = 1'b0;
  endtask

  task automatic drain();
    tick(3);
    res_pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!res_valid) break;
    end
    res_pop = 1'b0;
    check("drain_empty", 64'(res_valid), 64'd0);
  endtask

  task automatic pulse_clear();
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
  endtask

  function automatic logic [63:0] rand_value();
    int s;
    case ($urandom_range(0, 9))
      0:       return 64'h8000_0000_0000_0000;
      1:       return {$urandom, $urandom};
      default: begin
        s = int'($urandom_range(0, 80)) - 40;
        return 64'(longint'(s));
      end
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    logic [63:0] exp_lock [7];
    logic [63:0] peaks [7];
    logic [63:0] order [4];

    // Reset state
    tick(2);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_full",  64'(fifo_full), 64'd0);
    check("rst_ovf",   64'(overflow),  64'd0);
    check("rst_lock",  64'(lock),      64'd0);
    check("rst_mag",   64'(res_mag),   64'd0);
    rst = 1'b0;
    tick(1);

    // Peak with tie, latency of three edges
    threshold = 64'd15;
    win_len   = 8'd4;
    send(64'd5, 32'd100);
    send(-64'sd20, 32'd200);
    send(64'd20, 32'd300);
    send(64'd7, 32'd400);
    tick(1);
    check("t1_not_yet", 64'(res_valid), 64'd0);
    tick(1);
    check("t1_valid", 64'(res_valid), 64'd1);
    check("t1_mag",   64'(res_mag),   64'd20);
    check("t1_cnt",   64'(res_cnt),   64'd200);
    check("t1_epoch", 64'(res_epoch), 64'd1);
    check("t1_above", 64'(res_above), 64'd1);
    check("t1_model_mag", 64'(mq[0].mag), 64'd20);

    // Most negative input, win_len 1 and 0
    drain();
    win_len = 8'd1;
    send(64'h8000_0000_0000_0000, 32'd7);
    tick(2);
    check("t2_min_mag", res_mag, 64'h8000_0000_0000_0000);
    check("t2_min_ep",  64'(res_epoch), 64'd0);
    drain();
    win_len = 8'd0;
    send(-64'sd3, 32'd9);
    tick(2);
    check("t2_wl0_mag", res_mag, 64'd3);
    check("t2_wl0_cnt", 64'(res_cnt), 64'd9);

    // Lock sequence
    drain();
    threshold = 64'd50;
    win_len = 8'd1;
    peaks    = '{64'd60, -64'sd70, 64'd40, 64'd60, 64'd60, 64'd60, 64'd30};
    exp_lock = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd1, 64'd0};
    res_pop = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(peaks[i], 32'(i));
      tick(1);
      check($sformatf("t3_lock_w%0d", i + 1), 64'(lock), exp_lock[i]);
      tick(2);
    end
    res_pop = 1'b0;

    // FIFO overflow and simultaneous push/pop while full
    drain();
    pulse_clear();
    for (int k = 1; k <= 5; k++) send(64'(k * 10), 32'(k));
    tick(3);
    check("t4_full", 64'(fifo_full), 64'd1);
    check("t4_ovf",  64'(overflow),  64'd1);
    check("t4_head", res_mag, 64'd10);
    send(64'd60, 32'd6);
    tick(1);
    res_pop = 1'b1;
    tick(1);
    res_pop = 1'b0;
    check("t4_full2", 64'(fifo_full), 64'd1);
    check("t4_ovf2",  64'(overflow),  64'd1);
    check("t4_head2", res_mag, 64'd20);
    pulse_clear();
    check("t4_ovf_clr", 64'(overflow), 64'd0);
    order = '{64'd20, 64'd30, 64'd40, 64'd60};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_order%0d", i), res_mag, order[i]);
      res_pop = 1'b1;
      tick(1);
      res_pop = 1'b0;
    end

    // Enable dropped mid-window
    drain();
    win_len = 8'd4;
    send(64'd100, 32'd1);
    send(64'd100, 32'd2);
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    send(64'd1, 32'd11);
    send(64'd2, 32'd12);
    send(64'd3, 32'd13);
    send(64'd9, 32'd14);
    tick(2);
    check("t5_valid", 64'(res_valid), 64'd1);
    check("t5_mag",   res_mag, 64'd9);
    check("t5_epoch", 64'(res_epoch), 64'd3);
    res_pop = 1'b1;
    tick(1);
    res_pop = 1'b0;
    tick(3);
    check("t5_single", 64'(res_valid), 64'd0);

    // Asynchronous reset with lock and FIFO entries
    drain();
    win_len = 8'd1;
    for (int k = 0; k < 3; k++) send(64'd60, 32'(k));
    tick(3);
    check("t6_lock_pre", 64'(lock), 64'd1);
    res_pop = 1'b1;
    tick(1);
    res_pop = 1'b0;
    win_len = 8'd4;
    send(64'd5, 32'd1);
    send(64'd6, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t6_valid", 64'(res_valid), 64'd0);
    check("t6_full",  64'(fifo_full), 64'd0);
    check("t6_lock",  64'(lock),      64'd0);
    check("t6_mag",   res_mag,        64'd0);
    @(negedge clk);
    rst = 1'b0;
    win_len = 8'd2;
    send(64'd7, 32'd1);
    send(64'd3, 32'd2);
    tick(3);
    check("t6_fresh_mag", res_mag, 64'd7);
    check("t6_fresh_ep",  64'(res_epoch), 64'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      enable     = ($urandom_range(0, 99) >= 4);
      corr_valid = ($urandom_range(0, 99) < 60);
      corr_value = rand_value();
      corr_cnt   = $urandom;
      win_len    = 8'($urandom_range(0, 5));
      threshold  = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom}
                                               : 64'($urandom_range(0, 40));
      res_pop    = ($urandom_range(0, 99) < 35);
      clear_ovf  = ($urandom_range(0, 99) < 5);
      tick(1);
    end
    corr_valid = 1'b0;
    res_pop    = 1'b0;
    clear_ovf  = 1'b0;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
